// File: rtl/out_ctrl.sv
// rtl/out_ctrl.sv - stochastic bitstream frame counter with ready/valid result handoff
//
// Purpose: counts the ones in a frame of FRAME qualified stochastic bits and
// presents the count as a binary result. Frames run back to back while run is
// high, and each frame start steps the input tap delay line by one sample.
//
// Ports:
//   clock      - sole clock, rising edge
//   reset      - asynchronous, active-high reset
//   run        - level that enables frame conversion
//   bit_in     - stochastic bit from the FIR datapath
//   bit_en     - qualifies bit_in for the current cycle
//   sample_adv - one-cycle pulse at each frame start (tap delay line shift)
//   out_data   - ones count of the last completed frame, 0..FRAME
//   out_valid  - out_data holds an unconsumed result
//   out_ready  - downstream accepts out_data
//   busy       - high while accumulating a frame
//   overrun    - sticky: an unconsumed result was overwritten
module out_ctrl #(
   parameter int N     = 12,
   parameter int FRAME = 4096
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         run,
   input  logic         bit_in,
   input  logic         bit_en,
   output logic         sample_adv,
   output logic [N:0]   out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy,
   output logic         overrun
);

   typedef enum logic {IDLE, ACCUM} state_t;

   localparam logic [N-1:0] LAST = N'(FRAME - 1);

   state_t       state;
   logic [N:0]   ones_cnt;
   logic [N-1:0] frame_cnt;
   logic         frame_end;
   logic [N:0]   ones_next;

   // ones_cnt is one bit wider than frame_cnt so an all-ones frame reports FRAME
   assign ones_next = ones_cnt + {{N{1'b0}}, bit_in};
   assign frame_end = (state == ACCUM) && bit_en && (frame_cnt == LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         ones_cnt   <= '0;
         frame_cnt  <= '0;
         sample_adv <= 1'b0;
         busy       <= 1'b0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         sample_adv <= 1'b0;

         case (state)
            IDLE: begin
               if (run) begin
                  state      <= ACCUM;
                  busy       <= 1'b1;
                  ones_cnt   <= '0;
                  frame_cnt  <= '0;
                  sample_adv <= 1'b1;
               end
            end
            ACCUM: begin
               if (bit_en) begin
                  if (frame_cnt == LAST) begin
                     // run is only looked at here, so dropping it mid-frame
                     // still lets the current frame finish
                     ones_cnt  <= '0;
                     frame_cnt <= '0;
                     if (run) begin
                        sample_adv <= 1'b1;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                     ones_cnt  <= ones_next;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase

         // A load wins over a transfer in the same edge; overrun only flags a
         // result that was neither consumed before nor at this edge.
         if (frame_end) begin
            out_data  <= ones_next;
            out_valid <= 1'b1;
            if (out_valid && !out_ready) begin
               overrun <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_out_ctrl.sv
// tb/tb_out_ctrl.sv - directed self-checking bench for out_ctrl
module tb_out_ctrl;

   localparam int N     = 12;
   localparam int FRAME = 4096;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         run = 1'b0;
   logic         bit_in = 1'b0;
   logic         bit_en = 1'b0;
   logic         out_ready = 1'b0;
   logic         sample_adv;
   logic [N:0]   out_data;
   logic         out_valid;
   logic         busy;
   logic         overrun;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int adv_cnt = 0;
   int adv_base;
   int t0;

   out_ctrl #(.N(N), .FRAME(FRAME)) dut (
      .clock      (clock),
      .reset      (reset),
      .run        (run),
      .bit_in     (bit_in),
      .bit_en     (bit_en),
      .sample_adv (sample_adv),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .overrun    (overrun)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc = cyc + 1;
      if (sample_adv === 1'b1) adv_cnt = adv_cnt + 1;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // n qualified bits, the first `ones` of them are 1
   task automatic feed(input int n, input int ones);
      for (int i = 0; i < n; i++) begin
         bit_en = 1'b1;
         bit_in = (i < ones);
         tick();
      end
      bit_en = 1'b0;
      bit_in = 1'b0;
   endtask

   initial begin
      // reset state
      tick();
      tick();
      check("rst_out_data", 32'(out_data), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_sample_adv", 32'(sample_adv), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_overrun", 32'(overrun), 0);
      reset = 1'b0;
      bit_en = 1'b1;
      bit_in = 1'b1;
      tick();
      tick();
      check("idle_no_adv", 32'(adv_cnt), 0);
      check("idle_busy", 32'(busy), 0);
      bit_en = 1'b0;

      // alternating bits, run dropped right after the frame starts
      out_ready = 1'b1;
      adv_base = adv_cnt;
      run = 1'b1;
      tick();
      check("a_start_adv", 32'(sample_adv), 1);
      check("a_start_busy", 32'(busy), 1);
      run = 1'b0;
      for (int i = 0; i < FRAME - 1; i++) begin
         bit_en = 1'b1;
         bit_in = i[0];
         tick();
      end
      check("a_not_yet_valid", 32'(out_valid), 0);
      bit_in = 1'b1;
      tick();
      bit_en = 1'b0;
      check("a_valid", 32'(out_valid), 1);
      check("a_data", 32'(out_data), 2048);
      check("a_idle", 32'(busy), 0);
      tick();
      check("a_consumed", 32'(out_valid), 0);
      check("a_one_adv", 32'(adv_cnt - adv_base), 1);

      // all-ones frame then all-zeros frame, back to back
      run = 1'b1;
      tick();
      check("b_start_adv", 32'(sample_adv), 1);
      t0 = cyc;
      feed(FRAME, FRAME);
      check("b_data1", 32'(out_data), 4096);
      check("b_valid1", 32'(out_valid), 1);
      check("b_adv2", 32'(sample_adv), 1);
      check("b_adv_gap", 32'(cyc - t0), FRAME);
      check("b_busy", 32'(busy), 1);
      run = 1'b0;
      feed(FRAME, 0);
      check("b_data2", 32'(out_data), 0);
      check("b_valid2", 32'(out_valid), 1);
      check("b_overrun", 32'(overrun), 0);
      check("b_idle", 32'(busy), 0);
      tick();

      // 1000 unqualified cycles carrying bit_in=1 inside a 5096-cycle frame
      run = 1'b1;
      tick();
      run = 1'b0;
      for (int i = 0; i < FRAME + 1000; i++) begin
         if (i < 5000 && (i % 5) == 4) begin
            bit_en = 1'b0;
            bit_in = 1'b1;
         end else begin
            bit_en = 1'b1;
            bit_in = (i < 5000) && ((i % 5) == 0);
         end
         if (i == FRAME + 999) check("c_not_yet_valid", 32'(out_valid), 0);
         tick();
      end
      bit_en = 1'b0;
      bit_in = 1'b0;
      check("c_valid", 32'(out_valid), 1);
      check("c_data", 32'(out_data), 1000);
      tick();

      // out_ready rises exactly on the next frame-end edge
      out_ready = 1'b0;
      run = 1'b1;
      tick();
      feed(FRAME, 300);
      check("e_data1", 32'(out_data), 300);
      run = 1'b0;
      feed(FRAME - 1, 400);
      check("e_held_valid", 32'(out_valid), 1);
      check("e_held_data", 32'(out_data), 300);
      out_ready = 1'b1;
      feed(1, 0);
      check("e_data2", 32'(out_data), 400);
      check("e_valid2", 32'(out_valid), 1);
      check("e_overrun", 32'(overrun), 0);
      tick();
      check("e_consumed", 32'(out_valid), 0);

      // two frame ends with out_ready low
      out_ready = 1'b0;
      run = 1'b1;
      tick();
      feed(FRAME, 100);
      check("d_data1", 32'(out_data), 100);
      check("d_overrun1", 32'(overrun), 0);
      run = 1'b0;
      feed(FRAME, 200);
      check("d_data2", 32'(out_data), 200);
      check("d_valid2", 32'(out_valid), 1);
      check("d_overrun2", 32'(overrun), 1);
      out_ready = 1'b1;
      tick();
      tick();
      check("d_consumed", 32'(out_valid), 0);
      check("d_overrun_sticky", 32'(overrun), 1);

      // reset in the middle of a frame
      run = 1'b1;
      tick();
      run = 1'b0;
      feed(2000, 2000);
      check("f_busy_pre", 32'(busy), 1);
      reset = 1'b1;
      #1;
      check("f_async_busy", 32'(busy), 0);
      check("f_async_overrun", 32'(overrun), 0);
      check("f_async_data", 32'(out_data), 0);
      check("f_async_adv", 32'(sample_adv), 0);
      tick();
      reset = 1'b0;
      adv_base = adv_cnt;
      bit_en = 1'b1;
      bit_in = 1'b1;
      tick();
      tick();
      tick();
      bit_en = 1'b0;
      check("f_no_valid", 32'(out_valid), 0);
      check("f_no_adv", 32'(adv_cnt - adv_base), 0);
      run = 1'b1;
      tick();
      check("f_start_adv", 32'(sample_adv), 1);
      run = 1'b0;
      feed(FRAME, 50);
      check("f_valid", 32'(out_valid), 1);
      check("f_data", 32'(out_data), 50);
      check("f_overrun", 32'(overrun), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
